// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the sequencer state encoding and the instruction used as a pipeline bubble.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } ctrl_state_e;

  // addi x0, x0, 0 -- the canonical RV32 NOP loaded by a stage flush
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter for pipeline performance statistics.
// Clears on synchronous reset and sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use, taken branch,
// multi-cycle MUL/DIV waits and data-memory wait states, plus stall/flush statistics.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_is_load,
  input  logic              ex_br_taken,
  input  logic              ex_md_start,
  input  logic              md_done,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              idex_we,
  output logic              exmem_we,
  output logic              memwb_we,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              md_busy,
  output logic              md_timeout,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int              MD_CW   = $clog2(MD_TIMEOUT + 1);
  localparam logic [MD_CW-1:0] MD_LAST = MD_CW'(MD_TIMEOUT - 1);

  ctrl_state_e      state_reg, state_next;
  logic [MD_CW-1:0] md_cnt_reg, md_cnt_next;
  logic             md_timeout_reg, md_timeout_next;
  logic             mem_hold;
  logic             load_use;
  logic             flush_inc;
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [2];

  assign mem_hold = dmem_req & ~dmem_ready;
  assign load_use = ex_is_load & ex_regwrite & (ex_rd != '0) &
                    (((ex_rd == id_rs1) & id_use_rs1) | ((ex_rd == id_rs2) & id_use_rs2));

  always_comb begin
    pc_we           = 1'b1;
    ifid_we         = 1'b1;
    idex_we         = 1'b1;
    exmem_we        = 1'b1;
    memwb_we        = 1'b1;
    ifid_flush      = 1'b0;
    idex_flush      = 1'b0;
    exmem_flush     = 1'b0;
    flush_inc       = 1'b0;
    state_next      = state_reg;
    md_cnt_next     = md_cnt_reg;
    md_timeout_next = md_timeout_reg;

    if (rst) begin
      {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '0;
      {ifid_flush, idex_flush, exmem_flush}         = '1;
    end else if (mem_hold) begin
      // Full freeze: nothing moves and no pending event is consumed
      {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '0;
    end else if (state_reg == RUN) begin
      if (ex_br_taken) begin
        // ID holds a wrong-path instruction, so any load-use match is moot
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_inc  = 1'b1;
      end else if (ex_md_start) begin
        {pc_we, ifid_we, idex_we} = '0;
        exmem_flush = 1'b1;
        state_next  = MD_WAIT;
        md_cnt_next = '0;
      end else if (load_use) begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_flush = 1'b1;
      end
    end else begin
      if (md_done) begin
        state_next = RUN;
      end else if (md_cnt_reg == MD_LAST) begin
        // Give up on the unit and let the pipeline move; flag it stickily
        md_timeout_next = 1'b1;
        state_next      = RUN;
      end else begin
        {pc_we, ifid_we, idex_we} = '0;
        exmem_flush = 1'b1;
        md_cnt_next = md_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= RUN;
      md_cnt_reg     <= '0;
      md_timeout_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      md_cnt_reg     <= md_cnt_next;
      md_timeout_reg <= md_timeout_next;
    end
  end

  assign md_busy    = (state_reg == MD_WAIT);
  assign md_timeout = md_timeout_reg;

  // Index 0 counts stalled-PC cycles, index 1 counts branch flushes
  assign cnt_inc = {flush_inc, ~pc_we};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      hazard_sat_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (cnt_inc[gi]),
        .cnt (cnt_val[gi])
      );
    end
  endgenerate

  assign stall_cnt = cnt_val[0];
  assign flush_cnt = cnt_val[1];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed hazard scenarios with literal expectations,
// then randomized traffic compared every cycle against a table-driven behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int REG_AW     = 5;
  localparam int MD_TIMEOUT = 8;
  localparam int CNT_W      = 6;
  localparam int SAT        = (1 << CNT_W) - 1;

  // {pc, ifid, idex, exmem, memwb}_we , {ifid, idex, exmem}_flush
  localparam logic [7:0] P_DEFAULT = 8'b11111_000;
  localparam logic [7:0] P_FREEZE  = 8'b00000_000;
  localparam logic [7:0] P_BRANCH  = 8'b11111_110;
  localparam logic [7:0] P_MDSTALL = 8'b00011_001;
  localparam logic [7:0] P_LOADUSE = 8'b00111_010;
  localparam logic [7:0] P_RESET   = 8'b00000_111;

  logic              clk;
  logic              rst;
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
  logic              id_use_rs1, id_use_rs2, ex_regwrite, ex_is_load;
  logic              ex_br_taken, ex_md_start, md_done, dmem_req, dmem_ready;
  logic              pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic              ifid_flush, idex_flush, exmem_flush;
  logic              md_busy, md_timeout;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
  logic [7:0]        ctl;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_hazard_ctrl #(
    .REG_AW     (REG_AW),
    .MD_TIMEOUT (MD_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_regwrite (ex_regwrite),
    .ex_is_load  (ex_is_load),
    .ex_br_taken (ex_br_taken),
    .ex_md_start (ex_md_start),
    .md_done     (md_done),
    .dmem_req    (dmem_req),
    .dmem_ready  (dmem_ready),
    .pc_we       (pc_we),
    .ifid_we     (ifid_we),
    .idex_we     (idex_we),
    .exmem_we    (exmem_we),
    .memwb_we    (memwb_we),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .exmem_flush (exmem_flush),
    .md_busy     (md_busy),
    .md_timeout  (md_timeout),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  assign ctl = {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush, exmem_flush};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  bit m_valid = 0;
  bit m_busy, m_timeout;
  int m_wait, m_stall, m_flush;

  initial forever begin
    logic [7:0] e;
    logic       hold, lu;
    @(negedge clk);
    #3;
    hold = dmem_req && !dmem_ready;
    lu   = ex_is_load && ex_regwrite && (ex_rd != 0) &&
           ((ex_rd == id_rs1 && id_use_rs1) || (ex_rd == id_rs2 && id_use_rs2));
    if (rst)          e = P_RESET;
    else if (hold)    e = P_FREEZE;
    else if (!m_busy) e = ex_br_taken ? P_BRANCH : ex_md_start ? P_MDSTALL : lu ? P_LOADUSE : P_DEFAULT;
    else              e = (md_done || m_wait == MD_TIMEOUT - 1) ? P_DEFAULT : P_MDSTALL;

    chk("ctl", ctl, e);
    if (m_valid) begin
      chk("md_busy", md_busy, m_busy);
      chk("md_timeout", md_timeout, m_timeout);
      chk("stall_cnt", stall_cnt, m_stall);
      chk("flush_cnt", flush_cnt, m_flush);
    end

    if (rst) begin
      m_valid = 1; m_busy = 0; m_timeout = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e[7] && m_stall < SAT) m_stall++;
      if (e == P_BRANCH && m_flush < SAT) m_flush++;
      if (!hold) begin
        if (!m_busy) begin
          if (!ex_br_taken && ex_md_start) begin m_busy = 1; m_wait = 0; end
        end else if (md_done) begin
          m_busy = 0;
        end else if (m_wait == MD_TIMEOUT - 1) begin
          m_busy = 0; m_timeout = 1;
        end else begin
          m_wait++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    rst = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_rd = 0;
    ex_regwrite = 0; ex_is_load = 0; ex_br_taken = 0; ex_md_start = 0; md_done = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  initial begin
    int n;
    clr();
    rst = 1;
    #2 chk("reset ctl", ctl, P_RESET);
    repeat (2) cyc();

    clr(); #2;
    chk("post-reset ctl", ctl, P_DEFAULT);
    chk("post-reset stall_cnt", stall_cnt, 0);
    chk("post-reset flush_cnt", flush_cnt, 0);
    chk("post-reset md_busy", md_busy, 0);

    // Load-use on rs1
    cyc(); clr(); ex_is_load = 1; ex_regwrite = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; #2;
    chk("loaduse ctl", ctl, P_LOADUSE);
    cyc(); clr(); #2;
    chk("after loaduse ctl", ctl, P_DEFAULT);
    chk("loaduse stall_cnt", stall_cnt, 1);
    // Same with x0 as destination: no stall
    cyc(); clr(); ex_is_load = 1; ex_regwrite = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1; #2;
    chk("x0 load pc_we", pc_we, 1);

    // Taken branch wins over a load-use match
    cyc(); clr(); ex_br_taken = 1; ex_is_load = 1; ex_regwrite = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; #2;
    chk("branch ctl", ctl, P_BRANCH);
    cyc(); clr(); #2;
    chk("branch flush_cnt", flush_cnt, 1);
    chk("branch stall_cnt", stall_cnt, 1);

    // MUL/DIV with md_done five cycles after start
    cyc(); clr(); ex_md_start = 1; #2;
    chk("md_start ctl", ctl, P_MDSTALL);
    for (int i = 0; i < 4; i++) begin
      cyc(); clr(); #2;
      chk("md_wait busy", md_busy, 1);
      chk("md_wait exmem_flush", exmem_flush, 1);
    end
    cyc(); clr(); md_done = 1; #2;
    chk("md_done ctl", ctl, P_DEFAULT);
    chk("md_done busy", md_busy, 1);
    cyc(); clr(); #2;
    chk("md back to run", md_busy, 0);
    chk("md stall_cnt", stall_cnt, 6);

    // Memory wait during MD_WAIT freezes the wait counter, then the wait times out
    cyc(); clr(); ex_md_start = 1;
    repeat (2) begin cyc(); clr(); end
    repeat (3) begin
      cyc(); clr(); dmem_req = 1; #2;
      chk("hold ctl", ctl, P_FREEZE);
      chk("hold busy", md_busy, 1);
    end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(); clr(); #2;
      if (ctl == P_MDSTALL) n++;
      else break;
    end
    chk("stalls after hold", n, 5);
    chk("timeout release ctl", ctl, P_DEFAULT);
    cyc(); clr(); #2;
    chk("md_timeout set", md_timeout, 1);
    chk("hold stall_cnt", stall_cnt, 17);

    // Plain timeout: exactly MD_TIMEOUT stall cycles including the start cycle
    cyc(); clr(); ex_md_start = 1; #2;
    n = (ctl == P_MDSTALL) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      cyc(); clr(); #2;
      if (ctl == P_MDSTALL) n++;
      else break;
    end
    chk("timeout stall cycles", n, MD_TIMEOUT);
    chk("md_timeout sticky", md_timeout, 1);

    // Reset mid-wait
    cyc(); clr(); ex_md_start = 1;
    repeat (2) begin cyc(); clr(); end
    cyc(); clr(); rst = 1; #2;
    chk("mid-wait reset ctl", ctl, P_RESET);
    cyc(); clr(); #2;
    chk("reset ctl default", ctl, P_DEFAULT);
    chk("reset md_busy", md_busy, 0);
    chk("reset md_timeout", md_timeout, 0);
    chk("reset stall_cnt", stall_cnt, 0);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      cyc(); clr();
      rst         = ($urandom_range(0, 199) == 0);
      id_rs1      = REG_AW'($urandom_range(0, 3));
      id_rs2      = REG_AW'($urandom_range(0, 3));
      ex_rd       = REG_AW'($urandom_range(0, 3));
      id_use_rs1  = $urandom_range(0, 1) == 1;
      id_use_rs2  = $urandom_range(0, 1) == 1;
      ex_regwrite = $urandom_range(0, 3) != 0;
      ex_is_load  = $urandom_range(0, 2) == 0;
      ex_br_taken = $urandom_range(0, 9) == 0;
      ex_md_start = $urandom_range(0, 7) == 0;
      dmem_req    = $urandom_range(0, 4) == 0;
      dmem_ready  = $urandom_range(0, 1) == 1;
      md_done     = ($urandom_range(0, 6) == 0) && !(dmem_req && !dmem_ready);
    end
    cyc(); clr();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
